// File: rtl/coax_bus_ctrl.sv
// Host-side controller for the shared 10-bit bus to the coax datapath.
// Decodes host strobes and register select, and sequences bus direction with turnaround gaps.
module coax_bus_ctrl #(
   parameter int TURNAROUND = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       host_rd,
   input  logic       host_wr,
   input  logic [1:0] host_sel,
   input  logic [9:0] bus_in,
   output logic [9:0] bus_out,
   output logic       bus_oe,
   input  logic [9:0] rx_data,
   input  logic       rx_data_available,
   input  logic       rx_error,
   input  logic       rx_active,
   output logic       rx_read,
   output logic       rx_reset,
   output logic [9:0] tx_data,
   output logic       tx_load,
   input  logic       tx_ready,
   output logic       tx_enable
);

   typedef enum logic [2:0] {
      IDLE,
      RD_TURN,
      RD_DRIVE,
      RD_REL,
      WR_WAIT
   } state_t;

   localparam logic [3:0] TA_LAST = 4'(TURNAROUND - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       rd_q;
   logic       wr_q;
   logic       rd_edge;
   logic       wr_edge;
   logic [1:0] sel_q;
   logic       got_rx;
   logic       tx_overrun;
   logic [9:0] rd_word;

   assign rd_edge = host_rd & ~rd_q;
   assign wr_edge = host_wr & ~wr_q;

   always_comb begin
      rd_word = '0;
      case (host_sel)
         2'd0:    rd_word = rx_data_available ? rx_data : 10'h000;
         2'd1:    rd_word = {5'b0, tx_overrun, tx_ready, rx_active, rx_error, rx_data_available};
         2'd2:    rd_word = tx_data;
         default: rd_word = {8'b0, tx_enable, 1'b0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bus_out    <= '0;
         bus_oe     <= 1'b0;
         rx_read    <= 1'b0;
         rx_reset   <= 1'b0;
         tx_data    <= '0;
         tx_load    <= 1'b0;
         tx_enable  <= 1'b0;
         tx_overrun <= 1'b0;
         sel_q      <= '0;
         got_rx     <= 1'b0;
         // History keeps tracking during reset so a strobe held across reset is not a new edge
         rd_q       <= host_rd;
         wr_q       <= host_wr;
      end else begin
         rd_q     <= host_rd;
         wr_q     <= host_wr;
         rx_read  <= 1'b0;
         rx_reset <= 1'b0;
         tx_load  <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_edge) begin
                  sel_q   <= host_sel;
                  got_rx  <= rx_data_available;
                  bus_out <= rd_word;
                  cnt     <= '0;
                  if (TURNAROUND == 0) begin
                     bus_oe <= 1'b1;
                     state  <= RD_DRIVE;
                  end else begin
                     state  <= RD_TURN;
                  end
               end else if (wr_edge) begin
                  case (host_sel)
                     2'd2: begin
                        if (tx_ready) begin
                           tx_data <= bus_in;
                           tx_load <= 1'b1;
                        end else begin
                           tx_overrun <= 1'b1;
                        end
                     end
                     2'd3: begin
                        tx_enable <= bus_in[1];
                        rx_reset  <= bus_in[0];
                     end
                     default: ;
                  endcase
                  state <= WR_WAIT;
               end
            end
            RD_TURN: begin
               if (cnt == TA_LAST) begin
                  cnt    <= '0;
                  bus_oe <= 1'b1;
                  state  <= RD_DRIVE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RD_DRIVE: begin
               if (!host_rd) begin
                  bus_oe  <= 1'b0;
                  rx_read <= (sel_q == 2'd0) && got_rx;
                  if (sel_q == 2'd1)
                     tx_overrun <= 1'b0;
                  cnt   <= '0;
                  state <= (TURNAROUND == 0) ? IDLE : RD_REL;
               end
            end
            RD_REL: begin
               if (cnt == TA_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            WR_WAIT: begin
               if (!host_wr)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coax_bus_ctrl.sv
// Directed self-checking bench for coax_bus_ctrl with TURNAROUND=2.
// Read vectors come from a table; write, overrun, collision and reset cases are hand sequences.
module tb_coax_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       host_rd, host_wr;
   logic [1:0] host_sel;
   logic [9:0] bus_in, bus_out, rx_data, tx_data;
   logic       bus_oe, rx_data_available, rx_error, rx_active;
   logic       rx_read, rx_reset, tx_load, tx_ready, tx_enable;

   int checks = 0;
   int failures = 0;
   int rx_read_cnt = 0, tx_load_cnt = 0, rx_reset_cnt = 0, wide_cnt = 0;
   logic prev_rr = 1'b0, prev_tl = 1'b0, prev_rs = 1'b0;

   typedef struct {
      logic [1:0] sel;
      logic [9:0] rxd;
      logic       avail;
      logic       err;
      logic       act;
      logic       txr;
      logic [9:0] exp_bus;
      logic       exp_rd;
      string      tag;
   } vec_t;

   vec_t vecs[8];

   coax_bus_ctrl #(.TURNAROUND(2)) dut (
      .clk(clk), .reset(reset), .host_rd(host_rd), .host_wr(host_wr),
      .host_sel(host_sel), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
      .rx_data(rx_data), .rx_data_available(rx_data_available), .rx_error(rx_error),
      .rx_active(rx_active), .rx_read(rx_read), .rx_reset(rx_reset),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .tx_enable(tx_enable)
   );

   always #5 clk = ~clk;

   // Pulse counters and width watch, sampled mid-cycle
   always @(negedge clk) begin
      if (rx_read === 1'b1) rx_read_cnt++;
      if (tx_load === 1'b1) tx_load_cnt++;
      if (rx_reset === 1'b1) rx_reset_cnt++;
      if ((rx_read === 1'b1 && prev_rr) || (tx_load === 1'b1 && prev_tl) || (rx_reset === 1'b1 && prev_rs))
         wide_cnt++;
      prev_rr = (rx_read === 1'b1);
      prev_tl = (tx_load === 1'b1);
      prev_rs = (rx_reset === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rx_data           = v.rxd;
      rx_data_available = v.avail;
      rx_error          = v.err;
      rx_active         = v.act;
      tx_ready          = v.txr;
   endtask

   task automatic readTxn(input logic [1:0] sel, input logic exp_rd, input logic [9:0] exp_bus,
                          input string tag);
      int n;
      int rd_before;
      n = 0;
      host_sel = sel;
      host_rd  = 1'b1;
      while (bus_oe !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput({tag, " oe_delay"}, n, 3);
      checkOutput({tag, " bus_out"}, int'(bus_out), int'(exp_bus));
      host_sel = ~sel;
      tick();
      tick();
      checkOutput({tag, " bus_hold"}, int'({bus_oe, bus_out}), int'({1'b1, exp_bus}));
      rd_before = rx_read_cnt;
      host_rd = 1'b0;
      tick();
      checkOutput({tag, " release_oe"}, int'(bus_oe), 0);
      checkOutput({tag, " rx_read_aligned"}, int'(rx_read), int'(exp_rd));
      repeat (3) tick();
      checkOutput({tag, " rx_read_count"}, rx_read_cnt - rd_before, int'(exp_rd));
   endtask

   task automatic writeTxn(input logic [1:0] sel, input logic [9:0] data, input logic exp_load,
                           input logic exp_rst, input string tag);
      int ld_before;
      int rs_before;
      int oe_hi;
      ld_before = tx_load_cnt;
      rs_before = rx_reset_cnt;
      oe_hi = 0;
      bus_in   = data;
      host_sel = sel;
      host_wr  = 1'b1;
      tick();
      checkOutput({tag, " tx_load_now"}, int'(tx_load), int'(exp_load));
      checkOutput({tag, " rx_reset_now"}, int'(rx_reset), int'(exp_rst));
      bus_in = ~data;
      repeat (4) begin
         tick();
         if (bus_oe !== 1'b0) oe_hi++;
      end
      host_wr = 1'b0;
      repeat (2) tick();
      checkOutput({tag, " tx_load_count"}, tx_load_cnt - ld_before, int'(exp_load));
      checkOutput({tag, " rx_reset_count"}, rx_reset_cnt - rs_before, int'(exp_rst));
      checkOutput({tag, " wr_wait_oe"}, oe_hi, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int ld_before;
      int rd_before;
      int oe_hi;

      vecs[0] = '{2'd0, 10'h2A5, 1'b1, 1'b0, 1'b1, 1'b1, 10'h2A5, 1'b1, "rd_rx_avail"};
      vecs[1] = '{2'd0, 10'h1FF, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, "rd_rx_empty"};
      vecs[2] = '{2'd0, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b1, "rd_rx_ones"};
      vecs[3] = '{2'd1, 10'h155, 1'b1, 1'b0, 1'b1, 1'b1, 10'h00D, 1'b0, "rd_status_a"};
      vecs[4] = '{2'd1, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h002, 1'b0, "rd_status_b"};
      vecs[5] = '{2'd1, 10'h0F0, 1'b1, 1'b1, 1'b1, 1'b1, 10'h00F, 1'b0, "rd_status_c"};
      vecs[6] = '{2'd2, 10'h2A5, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, "rd_tx_init"};
      vecs[7] = '{2'd3, 10'h2A5, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, "rd_ctrl_init"};

      reset = 1'b1;
      host_rd = 1'b0;
      host_wr = 1'b0;
      host_sel = 2'd0;
      bus_in = '0;
      rx_data = '0;
      rx_data_available = 1'b0;
      rx_error = 1'b0;
      rx_active = 1'b0;
      tx_ready = 1'b0;
      repeat (3) tick();
      checkOutput("reset bus", int'({bus_oe, bus_out}), 0);
      checkOutput("reset pulses", int'({rx_read, rx_reset, tx_load}), 0);
      checkOutput("reset tx", int'({tx_enable, tx_data}), 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         readTxn(vecs[i].sel, vecs[i].exp_rd, vecs[i].exp_bus, vecs[i].tag);
      end

      // Overrun is sticky until a status read completes
      rx_data_available = 1'b0;
      rx_error = 1'b0;
      rx_active = 1'b0;
      tx_ready = 1'b0;
      writeTxn(2'd2, 10'h155, 1'b0, 1'b0, "wr_overrun");
      checkOutput("overrun tx_data", int'(tx_data), 0);
      writeTxn(2'd0, 10'h3FF, 1'b0, 1'b0, "wr_sel0_ignored");
      readTxn(2'd1, 1'b0, 10'h010, "status_ovr");
      readTxn(2'd1, 1'b0, 10'h000, "status_clr");

      tx_ready = 1'b1;
      writeTxn(2'd2, 10'h3C3, 1'b1, 1'b0, "wr_tx");
      checkOutput("wr_tx tx_data", int'(tx_data), 'h3C3);
      readTxn(2'd2, 1'b0, 10'h3C3, "rd_tx");
      writeTxn(2'd3, 10'h003, 1'b0, 1'b1, "wr_ctrl");
      checkOutput("wr_ctrl tx_enable", int'(tx_enable), 1);
      readTxn(2'd3, 1'b0, 10'h002, "rd_ctrl");
      writeTxn(2'd3, 10'h000, 1'b0, 1'b0, "wr_ctrl_off");
      checkOutput("wr_ctrl_off tx_enable", int'(tx_enable), 0);

      // Simultaneous strobes: read wins, write and later write edges dropped
      ld_before = tx_load_cnt;
      host_sel = 2'd2;
      bus_in = 10'h0AA;
      host_rd = 1'b1;
      host_wr = 1'b1;
      n = 0;
      while (bus_oe !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("both oe_delay", n, 3);
      checkOutput("both bus_out", int'(bus_out), 'h3C3);
      host_wr = 1'b0;
      tick();
      host_wr = 1'b1;
      tick();
      tick();
      checkOutput("both drive_oe", int'(bus_oe), 1);
      host_rd = 1'b0;
      host_wr = 1'b0;
      repeat (4) tick();
      checkOutput("both tx_data", int'(tx_data), 'h3C3);
      checkOutput("both tx_load_count", tx_load_cnt - ld_before, 0);

      // Reset while driving with host_rd held
      rx_data = 10'h2A5;
      rx_data_available = 1'b1;
      host_sel = 2'd0;
      host_rd = 1'b1;
      n = 0;
      while (bus_oe !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("rst_mid oe_delay", n, 3);
      tick();
      rd_before = rx_read_cnt;
      reset = 1'b1;
      tick();
      checkOutput("rst_mid oe_drop", int'(bus_oe), 0);
      tick();
      reset = 1'b0;
      oe_hi = 0;
      repeat (6) begin
         tick();
         if (bus_oe !== 1'b0) oe_hi++;
      end
      checkOutput("rst_mid held_no_read", oe_hi, 0);
      checkOutput("rst_mid rx_read_count", rx_read_cnt - rd_before, 0);
      checkOutput("rst_mid tx_cleared", int'({tx_enable, tx_data}), 0);
      host_rd = 1'b0;
      tick();
      readTxn(2'd0, 1'b1, 10'h2A5, "post_reset");

      checkOutput("pulse_width", wide_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
